// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deserialises 11-bit frames,
// folds E0/F0 prefixes into flags. Optional partial-frame timeout: define PS2_TIMEOUT_EN.
module ps2_scancode_rx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err
);

    localparam logic [7:0] BYTE_BREAK = 8'hF0;
    localparam logic [7:0] BYTE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ps2_scancode_rx: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ps2_scancode_rx: TIMEOUT_CYCLES must be >= 2");
    end

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   parity_q;
    logic                   break_pend_q;
    logic                   ext_pend_q;
    logic [7:0]             code_q;
    logic                   code_valid_q;
    logic                   is_break_q;
    logic                   is_ext_q;
    logic                   frame_err_q;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt_q;
`endif

    logic clk_s;
    logic data_s;
    logic fall;
    logic frame_good;

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign data_s     = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~clk_s;
    assign frame_good = data_s & (^{shift_q, parity_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            code_q       <= 8'd0;
            code_valid_q <= 1'b0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q   <= clk_s;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

`ifdef PS2_TIMEOUT_EN
            if (fall || state_q == S_IDLE) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
`endif

            if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!data_s) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_q <= data_s;
                        state_q  <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (!frame_good) begin
                            frame_err_q  <= 1'b1;
                            break_pend_q <= 1'b0;
                            ext_pend_q   <= 1'b0;
                        end else if (shift_q == BYTE_BREAK) begin
                            break_pend_q <= 1'b1;
                        end else if (shift_q == BYTE_EXT) begin
                            ext_pend_q <= 1'b1;
                        end else begin
                            code_q       <= shift_q;
                            code_valid_q <= 1'b1;
                            is_break_q   <= break_pend_q;
                            is_ext_q     <= ext_pend_q;
                            break_pend_q <= 1'b0;
                            ext_pend_q   <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
`ifdef PS2_TIMEOUT_EN
            end else if (state_q != S_IDLE && idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                // Stalled partial frame: drop it and flag the loss
                state_q      <= S_IDLE;
                frame_err_q  <= 1'b1;
                break_pend_q <= 1'b0;
                ext_pend_q   <= 1'b0;
`endif
            end
        end
    end

    assign code        = code_q;
    assign code_valid  = code_valid_q;
    assign is_break    = is_break_q;
    assign is_extended = is_ext_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx; the timeout scenario runs only with PS2_TIMEOUT_EN.
module tb_ps2_scancode_rx;

    localparam int unsigned TO_CYC = 200;
    localparam int unsigned HALF   = 10;

    typedef struct {
        logic       err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t       sb[$];
    logic       m_brk_pend = 1'b0;
    logic       m_ext_pend = 1'b0;
    logic [7:0] m_code = 8'd0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;

    ps2_scancode_rx #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .is_break   (is_break),
        .is_extended(is_extended),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1'b1; e.code = m_code; e.brk = m_brk; e.ext = m_ext;
        sb.push_back(e);
        m_brk_pend = 1'b0;
        m_ext_pend = 1'b0;
    endtask

    // Model the expected delivery, then drive the full frame
    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok);
        exp_t e;
        logic par;
        par = par_ok ? ~^b : ^b;
        if (!(par_ok && stop_ok)) begin
            push_err();
        end else if (b == 8'hF0) begin
            m_brk_pend = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext_pend = 1'b1;
        end else begin
            e.err = 1'b0; e.code = b; e.brk = m_brk_pend; e.ext = m_ext_pend;
            sb.push_back(e);
            m_code = b; m_brk = m_brk_pend; m_ext = m_ext_pend;
            m_brk_pend = 1'b0;
            m_ext_pend = 1'b0;
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop_ok);
        ps2_data = 1'b1;
        wait_clk(4 * HALF);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_code"}, 32'(code), 32'd0);
        chk({tag, "_valid"}, 32'(code_valid), 32'd0);
        chk({tag, "_brk"}, 32'(is_break), 32'd0);
        chk({tag, "_ext"}, 32'(is_extended), 32'd0);
        chk({tag, "_err"}, 32'(frame_err), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && (code_valid || frame_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, code_valid, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_err", 32'(frame_err), 32'(e.err));
                chk("code_valid", 32'(code_valid), 32'(!e.err));
                chk("code", 32'(code), 32'(e.code));
                chk("is_break", 32'(is_break), 32'(e.brk));
                chk("is_extended", 32'(is_extended), 32'(e.ext));
            end
        end
    end

    initial begin
        wait_clk(4);
        check_idle_outputs("reset");
        reset = 1'b0;
        wait_clk(10);

        send_frame(8'h16, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h16, 1'b1, 1'b1);
        send_frame(8'h16, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        send_frame(8'h45, 1'b0, 1'b1);
        send_frame(8'h45, 1'b1, 1'b0);
        // Pending break must be dropped by a bad frame
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h45, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h6B, 1'b1, 1'b1);

`ifdef PS2_TIMEOUT_EN
        push_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        wait_clk(TO_CYC + 50);
        send_frame(8'h1E, 1'b1, 1'b1);
`endif

        // Reset mid-frame after five data bits of 0x26
        begin
            logic [7:0] b;
            b = 8'h26;
            ps2_bit(1'b0);
            for (int i = 0; i < 5; i++) ps2_bit(b[i]);
        end
        wait_clk(3);
        reset = 1'b1;
        wait_clk(3);
        check_idle_outputs("midreset");
        reset = 1'b0;
        m_code = 8'd0; m_brk = 1'b0; m_ext = 1'b0;
        m_brk_pend = 1'b0; m_ext_pend = 1'b0;
        wait_clk(10);
        send_frame(8'h26, 1'b1, 1'b1);

        wait_clk(50);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
